// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC sampler slice.
// Used by adc_clk_div and adc_sampler (optional feature macro: ADC_SAMPLER_TRIGGER_EN).
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } adc_state_e;

    localparam int unsigned ADC_DATA_W          = 8;
    // 5000 iCLK cycles per half-period gives a 10 kHz ADC clock from 100 MHz
    localparam int unsigned ADC_HALF_PERIOD_10K = 5000;

endpackage

// File: rtl/adc_clk_div.sv
// ADC clock generator: run/stop FSM, half-period divider and latch, registered
// ADC clock / output enable, and a one-cycle strobe on every rising toggle.
module adc_clk_div
    import adc_pkg::*;
#(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] half_period,
    output adc_state_e       state,
    output logic             adc_clk,
    output logic             adc_noe,
    output logic             rise
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] half_lat;
    logic [DIV_W-1:0] half_eff;
    logic             wrap;

    always_comb begin
        half_eff = (half_period == '0) ? DIV_W'(1) : half_period;
        wrap     = (div_cnt == (half_lat - DIV_W'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            adc_clk  <= 1'b0;
            adc_noe  <= 1'b1;
            rise     <= 1'b0;
            div_cnt  <= '0;
            half_lat <= DIV_W'(1);
        end else begin
            rise <= 1'b0;
            case (state)
                ST_IDLE: begin
                    adc_clk <= 1'b0;
                    adc_noe <= 1'b1;
                    div_cnt <= '0;
                    if (enable) begin
                        state    <= ST_RUN;
                        adc_noe  <= 1'b0;
                        half_lat <= half_eff;
                    end
                end
                ST_RUN: begin
                    if (!enable && !adc_clk) begin
                        // low phase: stop at once, never start a new high pulse
                        state   <= ST_IDLE;
                        adc_noe <= 1'b1;
                        div_cnt <= '0;
                    end else if (wrap) begin
                        div_cnt  <= '0;
                        half_lat <= half_eff;
                        adc_clk  <= ~adc_clk;
                        rise     <= ~adc_clk;
                        if (!enable) begin
                            state   <= ST_IDLE;
                            adc_noe <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                        if (!enable) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    // finish the high phase at full length, then fall and park
                    if (wrap) begin
                        div_cnt <= '0;
                        adc_clk <= 1'b0;
                        adc_noe <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    adc_clk <= 1'b0;
                    adc_noe <= 1'b1;
                    div_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// ADC front end: programmable ADC clock, delayed byte capture, 1-entry valid/ready
// output with sticky overrun. Define ADC_SAMPLER_TRIGGER_EN to add the level trigger.
module adc_sampler
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W        = ADC_DATA_W,
    parameter int unsigned DIV_W         = 16,
    parameter int unsigned CAPTURE_DELAY = 2
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iEnable,
    input  logic [DIV_W-1:0]  iHalfPeriod,
    input  logic [DATA_W-1:0] iADC_Byte,
    output logic              oADC_CLK,
    output logic              oADC_nOE,
    output logic [DATA_W-1:0] oSample,
    output logic              oSampleValid,
    input  logic              iSampleReady,
    output logic              oOverrun
`ifdef ADC_SAMPLER_TRIGGER_EN
    ,
    input  logic [DATA_W-1:0] iTrigLevel,
    input  logic              iTrigArm,
    output logic              oTriggered
`endif
);

    localparam int unsigned DLY_W = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;

    adc_state_e        state;
    logic              rise;
    logic              start;
    logic              pend;
    logic [DLY_W-1:0]  dly_cnt;
    logic              cap_valid;
    logic [DATA_W-1:0] cap_data;
    logic              new_sample;

    adc_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk         (iCLK),
        .rst_n       (iRST_N),
        .enable      (iEnable),
        .half_period (iHalfPeriod),
        .state       (state),
        .adc_clk     (oADC_CLK),
        .adc_noe     (oADC_nOE),
        .rise        (rise)
    );

    always_comb begin
        start = (state == ST_IDLE) && iEnable;
    end

    // rise is one cycle behind the clock edge, so the capture lands CAPTURE_DELAY
    // cycles after the edge when the counter is loaded with CAPTURE_DELAY-1
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pend      <= 1'b0;
            dly_cnt   <= '0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            cap_valid <= 1'b0;
            if (state == ST_IDLE) begin
                pend <= 1'b0;
            end else if (rise) begin
                if (CAPTURE_DELAY <= 1) begin
                    cap_valid <= 1'b1;
                    cap_data  <= iADC_Byte;
                end else begin
                    pend    <= 1'b1;
                    dly_cnt <= DLY_W'(CAPTURE_DELAY - 1);
                end
            end else if (pend) begin
                if (dly_cnt == DLY_W'(1)) begin
                    pend      <= 1'b0;
                    cap_valid <= 1'b1;
                    cap_data  <= iADC_Byte;
                end else begin
                    dly_cnt <= dly_cnt - DLY_W'(1);
                end
            end
        end
    end

`ifdef ADC_SAMPLER_TRIGGER_EN
    logic [DATA_W-1:0] prev_sample;
    logic              have_prev;
    logic              fire;

    always_comb begin
        fire       = have_prev && (prev_sample < iTrigLevel) && (iTrigLevel <= cap_data);
        new_sample = cap_valid && (!iTrigArm || oTriggered || fire);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            prev_sample <= '0;
            have_prev   <= 1'b0;
            oTriggered  <= 1'b0;
        end else begin
            if (start) begin
                have_prev <= 1'b0;
            end else if (cap_valid) begin
                prev_sample <= cap_data;
                have_prev   <= 1'b1;
            end
            if (!iTrigArm) begin
                oTriggered <= 1'b0;
            end else if (cap_valid && fire) begin
                oTriggered <= 1'b1;
            end
        end
    end
`else
    always_comb begin
        new_sample = cap_valid;
    end
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oSample      <= '0;
            oSampleValid <= 1'b0;
            oOverrun     <= 1'b0;
        end else begin
            if (new_sample) begin
                if (!oSampleValid || iSampleReady) begin
                    oSample      <= cap_data;
                    oSampleValid <= 1'b1;
                end else begin
                    oOverrun <= 1'b1;
                end
            end else if (oSampleValid && iSampleReady) begin
                oSampleValid <= 1'b0;
            end
            if (start) begin
                oOverrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
// Directed self-checking bench for adc_sampler (trigger scenario only when
// ADC_SAMPLER_TRIGGER_EN is defined).
module tb_adc_sampler;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] half;
    logic [7:0]  adc_byte;
    logic        adc_clk;
    logic        noe;
    logic [7:0]  sample;
    logic        valid;
    logic        ready;
    logic        overrun;
`ifdef ADC_SAMPLER_TRIGGER_EN
    logic [7:0]  trig_level;
    logic        trig_arm;
    logic        triggered;
`endif

    int checks;
    int failures;
    bit ramp;

    adc_sampler #(
        .DATA_W        (8),
        .DIV_W         (16),
        .CAPTURE_DELAY (2)
    ) dut (
        .iCLK         (clk),
        .iRST_N       (rst_n),
        .iEnable      (enable),
        .iHalfPeriod  (half),
        .iADC_Byte    (adc_byte),
        .oADC_CLK     (adc_clk),
        .oADC_nOE     (noe),
        .oSample      (sample),
        .oSampleValid (valid),
        .iSampleReady (ready),
        .oOverrun     (overrun)
`ifdef ADC_SAMPLER_TRIGGER_EN
        ,
        .iTrigLevel   (trig_level),
        .iTrigArm     (trig_arm),
        .oTriggered   (triggered)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        if (ramp) adc_byte = adc_byte + 8'd1;
    endtask

    task automatic wait_rise(output bit ok);
        logic prev;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            prev = adc_clk;
            tick();
            if (!prev && adc_clk) ok = 1'b1;
        end
    endtask

    task automatic count_until(input logic lvl, output int n);
        n = 0;
        while (adc_clk !== lvl && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; half = 16'd5; adc_byte = 8'h00; ready = 1'b1; ramp = 1'b0;
`ifdef ADC_SAMPLER_TRIGGER_EN
        trig_level = 8'h80; trig_arm = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (adc_clk !== 1'b0) begin failures++; $display("FAIL reset_adc_clk got=%b exp=0", adc_clk); end
        checks++; if (noe !== 1'b1) begin failures++; $display("FAIL reset_noe got=%b exp=1", noe); end
        checks++; if (sample !== 8'h00) begin failures++; $display("FAIL reset_sample got=%h exp=00", sample); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_clock;
        bit ok;
        int n;
        half = 16'd5; enable = 1'b1;
        tick();
        checks++; if (noe !== 1'b0) begin failures++; $display("FAIL run_noe got=%b exp=0", noe); end
        checks++; if (adc_clk !== 1'b0) begin failures++; $display("FAIL run_clk_start got=%b exp=0", adc_clk); end
        wait_rise(ok);
        checks++; if (!ok) begin failures++; $display("FAIL clk_rise_timeout got=0 exp=1"); end
        count_until(1'b0, n);
        checks++; if (n !== 5) begin failures++; $display("FAIL clk_high5 got=%0d exp=5", n); end
        count_until(1'b1, n);
        checks++; if (n !== 5) begin failures++; $display("FAIL clk_low5 got=%0d exp=5", n); end
        half = 16'd3;
        count_until(1'b0, n);
        checks++; if (n !== 5) begin failures++; $display("FAIL clk_high_midchange got=%0d exp=5", n); end
        count_until(1'b1, n);
        checks++; if (n !== 3) begin failures++; $display("FAIL clk_low3 got=%0d exp=3", n); end
        count_until(1'b0, n);
        checks++; if (n !== 3) begin failures++; $display("FAIL clk_high3 got=%0d exp=3", n); end
        half = 16'd5;
    endtask

    task automatic test_capture;
        bit ok;
        logic [7:0] exp;
        ramp = 1'b1;
        for (int p = 0; p < 2; p++) begin
            wait_rise(ok);
            checks++; if (!ok) begin failures++; $display("FAIL cap_rise_timeout p=%0d got=0 exp=1", p); end
            exp = adc_byte + 8'd1;
            tick(); tick();
            checks++; if (valid !== 1'b0) begin failures++; $display("FAIL cap_early_valid p=%0d got=%b exp=0", p, valid); end
            tick();
            checks++; if (valid !== 1'b1) begin failures++; $display("FAIL cap_valid p=%0d got=%b exp=1", p, valid); end
            checks++; if (sample !== exp) begin failures++; $display("FAIL cap_sample p=%0d got=%h exp=%h", p, sample, exp); end
            tick();
            checks++; if (valid !== 1'b0) begin failures++; $display("FAIL cap_single_pulse p=%0d got=%b exp=0", p, valid); end
        end
    endtask

    task automatic test_overrun;
        bit ok;
        int n;
        logic [7:0] exp;
        wait_rise(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovr_rise_timeout got=0 exp=1"); end
        ready = 1'b0;
        exp = adc_byte + 8'd1;
        tick(); tick(); tick();
        checks++; if (valid !== 1'b1 || sample !== exp) begin failures++; $display("FAIL ovr_first got=%b/%h exp=1/%h", valid, sample, exp); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_not_yet got=%b exp=0", overrun); end
        for (int p = 0; p < 2; p++) begin
            wait_rise(ok);
            tick(); tick(); tick();
        end
        checks++; if (sample !== exp) begin failures++; $display("FAIL ovr_held got=%h exp=%h", sample, exp); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_held got=%b exp=1", valid); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        ready = 1'b1;
        tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got=%b exp=0", valid); end
        enable = 1'b0;
        n = 0;
        while (noe !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (noe !== 1'b1) begin failures++; $display("FAIL ovr_idle_noe got=%b exp=1", noe); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        enable = 1'b1;
        tick();
        checks++; if (noe !== 1'b0) begin failures++; $display("FAIL ovr_rerun_noe got=%b exp=0", noe); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_stop;
        bit ok;
        logic [7:0] exp;
        half = 16'd4;
        wait_rise(ok);
        checks++; if (!ok) begin failures++; $display("FAIL stop_rise_timeout got=0 exp=1"); end
        exp = adc_byte + 8'd1;
        enable = 1'b0;
        tick();
        checks++; if (adc_clk !== 1'b1) begin failures++; $display("FAIL stop_high1 got=%b exp=1", adc_clk); end
        tick(); tick();
        checks++; if (adc_clk !== 1'b1) begin failures++; $display("FAIL stop_high3 got=%b exp=1", adc_clk); end
        checks++; if (valid !== 1'b1 || sample !== exp) begin failures++; $display("FAIL stop_capture got=%b/%h exp=1/%h", valid, sample, exp); end
        checks++; if (noe !== 1'b0) begin failures++; $display("FAIL stop_noe_run got=%b exp=0", noe); end
        tick();
        checks++; if (adc_clk !== 1'b0) begin failures++; $display("FAIL stop_fall got=%b exp=0", adc_clk); end
        checks++; if (noe !== 1'b1) begin failures++; $display("FAIL stop_idle_noe got=%b exp=1", noe); end
        half = 16'd5;
    endtask

    task automatic test_async_reset;
        bit ok;
        enable = 1'b1;
        wait_rise(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ares_rise_timeout got=0 exp=1"); end
        ready = 1'b0;
        tick(); tick(); tick();
        checks++; if (valid !== 1'b1 || adc_clk !== 1'b1) begin failures++; $display("FAIL ares_pre got=%b/%b exp=1/1", valid, adc_clk); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (adc_clk !== 1'b0) begin failures++; $display("FAIL ares_clk got=%b exp=0", adc_clk); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ares_valid got=%b exp=0", valid); end
        checks++; if (noe !== 1'b1) begin failures++; $display("FAIL ares_noe got=%b exp=1", noe); end
        enable = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef ADC_SAMPLER_TRIGGER_EN
    task automatic test_trigger;
        bit ok;
        int fwd;
        logic [7:0] first;
        logic [7:0] vals [4];
        vals[0] = 8'h10; vals[1] = 8'h40; vals[2] = 8'h90; vals[3] = 8'hC0;
        ramp = 1'b0; trig_level = 8'h80; trig_arm = 1'b1; half = 16'd5; ready = 1'b1;
        enable = 1'b1;
        fwd = 0; first = 8'h00;
        for (int i = 0; i < 4; i++) begin
            wait_rise(ok);
            adc_byte = vals[i];
            tick(); tick(); tick();
            if (valid === 1'b1) begin
                if (fwd == 0) first = sample;
                fwd++;
            end
            if (i == 1) begin
                checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL trig_early got=%b exp=0", triggered); end
            end
        end
        checks++; if (first !== 8'h90) begin failures++; $display("FAIL trig_first got=%h exp=90", first); end
        checks++; if (fwd !== 2) begin failures++; $display("FAIL trig_count got=%0d exp=2", fwd); end
        checks++; if (triggered !== 1'b1) begin failures++; $display("FAIL trig_flag got=%b exp=1", triggered); end
        trig_arm = 1'b0;
        tick();
        checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL trig_disarm got=%b exp=0", triggered); end
        enable = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_clock();
        test_capture();
        test_overrun();
        test_stop();
        test_async_reset();
`ifdef ADC_SAMPLER_TRIGGER_EN
        test_trigger();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
